// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit scheduler: FSM state
// encoding, default header tag and the header byte builder.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    HOLD_H = 3'd2,
    LOAD   = 3'd3,
    SEND   = 3'd4,
    HOLD_D = 3'd5
  } state_e;

  localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;

  function automatic logic [7:0] make_header(input logic [3:0] tag, input logic [2:0] idx);
    return {tag, 1'b0, idx};
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N. Produces one-hot and binary forms of the winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  input  logic         en,
  output logic [N-1:0] gnt,
  output logic [2:0]   idx
);

  // Scan offsets from ptr; the first hit locks out every later candidate.
  always_comb begin : arb
    logic found;
    logic hit;
    found = 1'b0;
    hit   = 1'b0;
    gnt   = {N{1'b0}};
    idx   = 3'd0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        hit    = en & ~found & req[j] & (((int'(ptr) + i) % N) == j);
        gnt[j] = gnt[j] | hit;
        idx    = hit ? 3'(j) : idx;
        found  = found | hit;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among N_REQ byte streams with packet-level
// round-robin grants, optional channel header and a LOAD-state timeout.
module uart_tx_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter int         N_REQ     = 4,
  parameter bit         HEADER_EN = 1'b1,
  parameter logic [3:0] HDR_TAG   = HDR_TAG_DEFAULT,
  parameter int         TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [N_REQ-1:0]     grant,
  output logic                 pkt_done,
  output logic                 timeout_err
);

  localparam int CW = $clog2(TIMEOUT);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             last_q, last_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             pkt_done_q, pkt_done_d;
  logic             timeout_err_q, timeout_err_d;

  logic [N_REQ-1:0] arb_gnt_s;
  logic [2:0]       arb_idx_s;
  logic             xfer_s;
  logic [7:0]       sel_byte_s;
  logic             sel_last_s;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (enable & (state_q == IDLE)),
    .gnt (arb_gnt_s),
    .idx (arb_idx_s)
  );

  assign req_ready   = (state_q == LOAD) ? grant_q : {N_REQ{1'b0}};
  assign xfer_s      = |(req_valid & req_ready);
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant       = grant_q;
  assign pkt_done    = pkt_done_q;
  assign timeout_err = timeout_err_q;

  // Byte and last flag of the current owner.
  always_comb begin
    sel_byte_s = 8'h00;
    sel_last_s = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      sel_byte_s = (idx_q == 3'(j)) ? req_data[8*j +: 8] : sel_byte_s;
      sel_last_s = (idx_q == 3'(j)) ? req_last[j] : sel_last_s;
    end
  end

  // Next-state and registered-output logic of the scheduler FSM.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    idx_d         = idx_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    byte_d        = byte_q;
    last_d        = last_q;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    pkt_done_d    = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && (|req_valid)) begin
          grant_d = arb_gnt_s;
          idx_d   = arb_idx_s;
          ptr_d   = (arb_idx_s == 3'(N_REQ - 1)) ? 3'd0 : arb_idx_s + 3'd1;
          cnt_d   = {CW{1'b0}};
          state_d = HEADER_EN ? HDR : LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      HDR: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = make_header(HDR_TAG, idx_q);
          state_d    = HOLD_H;
        end else begin
          state_d = HDR;
        end
      end
      HOLD_H: begin
        state_d = LOAD;
      end
      LOAD: begin
        // A transfer in the final count cycle still wins over the timeout.
        if (xfer_s) begin
          byte_d  = sel_byte_s;
          last_d  = sel_last_s;
          cnt_d   = {CW{1'b0}};
          state_d = SEND;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          grant_d       = {N_REQ{1'b0}};
          cnt_d         = {CW{1'b0}};
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = byte_q;
          state_d    = HOLD_D;
        end else begin
          state_d = SEND;
        end
      end
      HOLD_D: begin
        if (last_q) begin
          pkt_done_d = 1'b1;
          grant_d    = {N_REQ{1'b0}};
          state_d    = IDLE;
        end else begin
          state_d = LOAD;
        end
      end
      default: begin
        grant_d = {N_REQ{1'b0}};
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= {N_REQ{1'b0}};
      idx_q         <= 3'd0;
      ptr_q         <= 3'd0;
      cnt_q         <= {CW{1'b0}};
      byte_q        <= 8'h00;
      last_q        <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      pkt_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      idx_q         <= idx_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      byte_q        <= byte_d;
      last_q        <= last_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      pkt_done_q    <= pkt_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: requester queues, a busy model of
// the transmitter, and a monitor that checks every start against expectations.
module tb_uart_tx_scheduler;
  localparam int N        = 4;
  localparam int TMO      = 1024;
  localparam int BYTE_CYC = 20;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           enable = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [N-1:0]   grant;
  logic           pkt_done;
  logic           timeout_err;

  logic           force_busy = 1'b0;
  int             busy_cnt = 0;
  logic           busy_st;
  logic [N-1:0]   phantom = '0;
  logic [N-1:0]   hs;
  logic [8:0]     rq [N][$];
  logic [7:0]     exp_q [$];
  logic [7:0]     mon_exp;
  logic           prev_busy = 1'b0;
  logic           prev_start = 1'b0;
  int             checks = 0, errors = 0;
  int             start_cnt = 0, pkt_cnt = 0, to_cnt = 0;
  int             t, cnt, snap;

  assign tx_busy = (busy_cnt != 0) || force_busy;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.N_REQ(N), .HEADER_EN(1'b1), .HDR_TAG(4'hA), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(req_valid),
    .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .grant(grant),
    .pkt_done(pkt_done), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Transmitter model: busy rises one edge after it samples start, not reset by rst_n.
  initial forever begin
    @(negedge clk);
    busy_st = tx_start;
    @(posedge clk);
    #1;
    if (busy_st) busy_cnt = BYTE_CYC;
    else if (busy_cnt > 0) busy_cnt--;
  end

  // Requester driver: pop accepted bytes, present the next queue head.
  initial forever begin
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      req_valid[i]       = (rq[i].size() > 0) || phantom[i];
      req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
      req_last[i]        = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
    end
  end

  // Monitor: every start is popped from the scoreboard and compared.
  initial forever begin
    @(negedge clk);
    if (rst_n && tx_start) begin
      start_cnt++;
      check("start_while_busy", {31'b0, prev_busy}, 32'd0);
      check("start_single_cycle", {31'b0, prev_start}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start: tx_data=%0h with empty scoreboard", tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tx_data", {24'b0, tx_data}, {24'b0, mon_exp});
      end
    end
    if (rst_n && pkt_done) pkt_cnt++;
    if (rst_n && timeout_err) to_cnt++;
    prev_busy  = tx_busy;
    prev_start = tx_start;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pkts(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (pkt_cnt < n && k < budget) begin tick(); k++; end
    check(name, pkt_cnt, n);
  endtask

  task automatic wait_grant(input logic [N-1:0] g, input int budget, input string name);
    int k;
    k = 0;
    while (grant !== g && k < budget) begin tick(); k++; end
    check(name, {28'b0, grant}, {28'b0, g});
  endtask

  task automatic apply_reset();
    tick();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick();
    check("rst_grant", {28'b0, grant}, 32'd0);
    check("rst_tx_start", {31'b0, tx_start}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data}, 32'd0);
    check("rst_pkt_done", {31'b0, pkt_done}, 32'd0);
    check("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
    check("rst_req_ready", {28'b0, req_ready}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    enable = 1'b1;

    // 1: single packet with header
    tick();
    rq[0].push_back({1'b0, 8'h11}); rq[0].push_back({1'b1, 8'h22});
    exp_q.push_back(8'hA0); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    wait_pkts(1, 400, "t1_pkt_done");
    check("t1_grant_idle", {28'b0, grant}, 32'd0);
    check("t1_starts", start_cnt, 3);
    check("t1_drained", exp_q.size(), 0);
    repeat (30) tick();

    // 2: round robin from reset, req2 beats req0's second packet
    apply_reset();
    tick();
    rq[0].push_back({1'b1, 8'h33}); rq[0].push_back({1'b1, 8'h66});
    rq[2].push_back({1'b0, 8'h44}); rq[2].push_back({1'b1, 8'h55});
    exp_q.push_back(8'hA0); exp_q.push_back(8'h33);
    exp_q.push_back(8'hA2); exp_q.push_back(8'h44); exp_q.push_back(8'h55);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h66);
    wait_pkts(4, 1500, "t2_pkts");
    check("t2_drained", exp_q.size(), 0);

    // 3: req1 stalls after header, req3 waiting
    phantom[1] = 1'b1;
    rq[3].push_back({1'b1, 8'h77});
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA3); exp_q.push_back(8'h77);
    wait_grant(4'b0010, 100, "t3_grant_req1");
    phantom[1] = 1'b0;
    cnt = 0; t = 0;
    while (!timeout_err && t < TMO + 300) begin
      if (req_ready != '0) cnt++;
      tick(); t++;
    end
    check("t3_timeout_pulse", {31'b0, timeout_err}, 32'd1);
    check("t3_grant_cleared", {28'b0, grant}, 32'd0);
    check("t3_load_cycles", cnt, TMO);
    tick();
    check("t3_pulse_width", {31'b0, timeout_err}, 32'd0);
    wait_pkts(5, 400, "t3_req3_pkt");
    check("t3_timeout_count", to_cnt, 1);
    repeat (30) tick();

    // 4: transmitter held busy during SEND
    rq[0].push_back({1'b1, 8'h88});
    exp_q.push_back(8'hA0); exp_q.push_back(8'h88);
    snap = start_cnt; t = 0;
    while (start_cnt == snap && t < 100) begin tick(); t++; end
    check("t4_header_start", start_cnt, snap + 1);
    @(posedge clk); #2; force_busy = 1'b1;
    snap = start_cnt;
    repeat (50) tick();
    check("t4_no_start_while_busy", start_cnt, snap);
    @(posedge clk); #2; force_busy = 1'b0;
    wait_pkts(6, 200, "t4_pkt_done");
    check("t4_one_start_after_busy", start_cnt, snap + 1);
    repeat (30) tick();

    // 5: reset during HOLD_D of a 3-byte packet
    rq[1].push_back({1'b0, 8'h99}); rq[1].push_back({1'b0, 8'hAA}); rq[1].push_back({1'b1, 8'hBB});
    exp_q.push_back(8'hA1); exp_q.push_back(8'h99);
    t = 0;
    while (!(tx_start && tx_data == 8'h99) && t < 300) begin tick(); t++; end
    check("t5_reached_hold_d", {24'b0, tx_data}, 32'h99);
    rst_n = 1'b0;
    rq[1].delete();
    #1;
    check("t5_rst_tx_start", {31'b0, tx_start}, 32'd0);
    check("t5_rst_tx_data", {24'b0, tx_data}, 32'd0);
    check("t5_rst_grant", {28'b0, grant}, 32'd0);
    check("t5_rst_ready", {28'b0, req_ready}, 32'd0);
    check("t5_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2; rst_n = 1'b1;
    tick();
    rq[2].push_back({1'b1, 8'hCC});
    exp_q.push_back(8'hA2); exp_q.push_back(8'hCC);
    snap = start_cnt;
    repeat (4) tick();
    check("t5_wait_for_busy", start_cnt, snap);
    wait_pkts(7, 300, "t5_pkt_after_reset");
    repeat (30) tick();

    // 6: enable gating
    enable = 1'b0;
    rq[0].push_back({1'b0, 8'hD1}); rq[0].push_back({1'b0, 8'hD2}); rq[0].push_back({1'b1, 8'hD3});
    exp_q.push_back(8'hA0); exp_q.push_back(8'hD1); exp_q.push_back(8'hD2); exp_q.push_back(8'hD3);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (grant != '0) cnt++; end
    check("t6_no_grant_disabled", cnt, 0);
    enable = 1'b1;
    wait_grant(4'b0001, 20, "t6_grant_req0");
    enable = 1'b0;
    wait_pkts(8, 400, "t6_pkt_completes");
    rq[0].push_back({1'b1, 8'hE1});
    snap = start_cnt; cnt = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (grant != '0) cnt++; end
    check("t6_idle_holds", cnt, 0);
    check("t6_no_start", start_cnt, snap);
    check("final_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
